clock_ctrl: RTL

- Clock-enable controller for the catalog clock: sequences when downstream elements may advance.
- Produces a one-cycle `tick` enable every `div` cycles of the free-running `clk`.
- Supports run, stop-with-drain and single-step modes; the divider is programmable while idle.
- Sits between the clock source and any stateful catalog element that has an `en` input.

---
 rtl/clock_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: clock-enable sequencer for the catalog clock.
// Issues a one-cycle tick every div_eff cycles of clk, where
// div_eff = (div_cur == 0) ? 1 : div_cur. Supports free run (en),
// stop-with-drain (en dropped mid-period) and single step (step).
// The divider may only be reloaded while idle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         level run request
//   step       one-cycle request for exactly one tick
//   div_load   load div_in into the divider (idle only)
//   div_in     new divider value
//   tick       one-cycle clock-enable pulse
//   running    high in RUN or DRAIN
//   busy       high in any state but IDLE
//   load_err   one-cycle pulse after a rejected div_load
//   div_cur    active divider value
//   tick_count total ticks issued, wraps silently
module clock_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  output logic             tick,
  output logic             running,
  output logic             busy,
  output logic             load_err,
  output logic [DIV_W-1:0] div_cur,
  output logic [CNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STEP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic             period_end;

  // A zero divider means "tick every cycle", never a stall.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  assign div_eff    = eff_div(div_cur);
  assign period_end = (cnt == div_eff - DIV_W'(1));

  // Moore decode of registered state only; no input reaches these outputs.
  assign tick    = (state != IDLE) && period_end;
  assign running = (state == RUN) || (state == DRAIN);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (en)        state_nxt = RUN;
        else if (step) state_nxt = STEP;
      end
      RUN: begin
        if (!en) state_nxt = period_end ? IDLE : DRAIN;
      end
      DRAIN: begin
        // Re-asserting en resumes the same period without a restart.
        if (en)              state_nxt = RUN;
        else if (period_end) state_nxt = IDLE;
      end
      STEP: begin
        if (period_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Period counter: held at 0 in IDLE so every exit starts a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (period_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Divider register and load rejection flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cur  <= DIV_W'(DEFAULT_DIV);
      load_err <= 1'b0;
    end else begin
      load_err <= div_load && (state != IDLE);
      if (div_load && (state == IDLE)) div_cur <= div_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_count <= '0;
    end else if (tick) begin
      tick_count <= tick_count + CNT_W'(1);
    end
  end

endmodule
